// File: rtl/entity_renderer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : entity_renderer_pkg
// Description : Shared entity/state codes, VGA timing defaults, colour
//               constants and test palette for the entity renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package entity_renderer_pkg;

    // Entity codes exchanged with game logic
    localparam int ENT_LADDR      = 3;
    localparam int ENT_W          = ENT_LADDR + 1;
    localparam int ENT_NOTHING    = 0;
    localparam int ENT_SNAKE_HEAD = 1;
    localparam int ENT_SNAKE_TAIL = 2;
    localparam int ENT_APPLE      = 3;
    localparam int ENT_WALL       = 4;

    // Game state codes
    localparam logic [2:0] STATE_START    = 3'd0;
    localparam logic [2:0] STATE_INGAME   = 3'd1;
    localparam logic [2:0] STATE_PAUSE    = 3'd2;
    localparam logic [2:0] STATE_GAMEOVER = 3'd3;
    localparam logic [2:0] STATE_TEST     = 3'd4;

    // Grid cell size in pixels
    localparam int H_SQUARE = 16;
    localparam int V_SQUARE = 16;

    // 640x480@60 timing defaults
    localparam int H_VISIBLE_D = 640;
    localparam int H_FP_D      = 16;
    localparam int H_SYNC_D    = 96;
    localparam int H_BP_D      = 48;
    localparam int V_VISIBLE_D = 480;
    localparam int V_FP_D      = 10;
    localparam int V_SYNC_D    = 2;
    localparam int V_BP_D      = 33;
    localparam int H_TOTAL     = H_VISIBLE_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int V_TOTAL     = V_VISIBLE_D + V_FP_D + V_SYNC_D + V_BP_D;

    // Colour format {R[3:0],G[3:0],B[3:0]}
    localparam int COLOR_W = 12;
    typedef logic [COLOR_W-1:0] color_t;

    localparam color_t COL_BLACK      = 12'h000;
    localparam color_t COL_FLASH      = 12'h800;
    localparam color_t COL_WALL       = 12'h888;
    localparam color_t COL_APPLE      = 12'hF00;
    localparam color_t COL_HEAD       = 12'h0F0;
    localparam color_t COL_TAIL       = 12'h0A0;
    localparam color_t COL_TAIL_EDGE  = 12'h050;
    localparam color_t COL_ERROR      = 12'hF0F;

    // Colour-bar palette used in test mode
    function automatic color_t test_palette(input logic [2:0] idx);
        color_t c;
        case (idx)
            3'd0:    c = 12'h000;
            3'd1:    c = 12'hF00;
            3'd2:    c = 12'h0F0;
            3'd3:    c = 12'h00F;
            3'd4:    c = 12'hFF0;
            3'd5:    c = 12'h0FF;
            3'd6:    c = 12'hF0F;
            default: c = 12'hFFF;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/entity_renderer_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : Raster counters, raw active/sync windows and the once-per-
//               frame tick (first blank line) for the entity renderer.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       active,
    output logic       hs_raw,
    output logic       vs_raw,
    output logic       frame_tick
);

    localparam int H_TOTAL_L = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL_L = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] c_h_last     = 10'(H_TOTAL_L - 1);
    localparam logic [9:0] c_v_last     = 10'(V_TOTAL_L - 1);
    localparam logic [9:0] c_h_vis      = 10'(H_VISIBLE);
    localparam logic [9:0] c_v_vis      = 10'(V_VISIBLE);
    localparam logic [9:0] c_hs_start   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] c_hs_end     = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] c_vs_start   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] c_vs_end     = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] w_h_next;
    logic [9:0] w_v_next;

    // Next raster position: h wraps at end of line, v advances only on h wrap
    always_comb begin
        w_h_next = h_cnt + 10'd1;
        w_v_next = v_cnt;
        if (h_cnt == c_h_last) begin
            w_h_next = 10'd0;
            w_v_next = (v_cnt == c_v_last) ? 10'd0 : v_cnt + 10'd1;
        end
    end

    // Counter registers; the tick is looked ahead so it coincides with (0, V_VISIBLE)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt      <= 10'd0;
            v_cnt      <= 10'd0;
            frame_tick <= 1'b0;
        end else begin
            h_cnt      <= w_h_next;
            v_cnt      <= w_v_next;
            frame_tick <= (w_h_next == 10'd0) && (w_v_next == c_v_vis);
        end
    end

    assign active = (h_cnt < c_h_vis) && (v_cnt < c_v_vis);
    assign hs_raw = (h_cnt >= c_hs_start) && (h_cnt < c_hs_end);
    assign vs_raw = (v_cnt >= c_vs_start) && (v_cnt < c_vs_end);

endmodule
`default_nettype wire

// File: rtl/entity_renderer.sv
`default_nettype none
// ============================================================================
// Module      : entity_renderer
// Description : VGA raster generator that hands pixel coordinates to game
//               logic, takes back the entity code one cycle later and maps
//               it to 12-bit RGB with cell borders and game-over flash.
// Revision    : 1.0 - initial release
// ============================================================================
module entity_renderer
    import entity_renderer_pkg::*;
#(
    parameter int   H_VISIBLE = H_VISIBLE_D,
    parameter int   H_FP      = H_FP_D,
    parameter int   H_SYNC    = H_SYNC_D,
    parameter int   H_BP      = H_BP_D,
    parameter int   V_VISIBLE = V_VISIBLE_D,
    parameter int   V_FP      = V_FP_D,
    parameter int   V_SYNC    = V_SYNC_D,
    parameter int   V_BP      = V_BP_D,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   ENT_W     = entity_renderer_pkg::ENT_W,
    parameter int   FLASH_BIT = 3
) (
    input  logic               vga_clk,
    input  logic               reset_p,
    input  logic [ENT_W-1:0]   entity,
    input  logic [2:0]         game_state,
    input  logic               game_over,
    output logic [9:0]         x_out,
    output logic [9:0]         y_out,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] rgb,
    output logic               frame_tick
);

    localparam int CX_W = $clog2(H_SQUARE);
    localparam int CY_W = $clog2(V_SQUARE);

    logic [9:0]      w_h_cnt;
    logic [9:0]      w_v_cnt;
    logic            w_active;
    logic            w_hs_raw;
    logic            w_vs_raw;

    logic            r1_active;
    logic            r1_hs;
    logic            r1_vs;
    logic [CX_W-1:0] r1_cx;
    logic [CY_W-1:0] r1_cy;

    logic [4:0]      r_flash_cnt;
    logic            w_flash_on;
    color_t          w_rgb;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP)
    ) u_timing (
        .clk        (vga_clk),
        .rst        (reset_p),
        .h_cnt      (w_h_cnt),
        .v_cnt      (w_v_cnt),
        .active     (w_active),
        .hs_raw     (w_hs_raw),
        .vs_raw     (w_vs_raw),
        .frame_tick (frame_tick)
    );

    // Stage 0: the counters are the coordinates game logic samples
    assign x_out = w_h_cnt;
    assign y_out = w_v_cnt;

    // Stage 1: delay timing and cell offsets to line up with the returned entity
    always_ff @(posedge vga_clk or posedge reset_p) begin
        if (reset_p) begin
            r1_active <= 1'b0;
            r1_hs     <= 1'b0;
            r1_vs     <= 1'b0;
            r1_cx     <= '0;
            r1_cy     <= '0;
        end else begin
            r1_active <= w_active;
            r1_hs     <= w_hs_raw;
            r1_vs     <= w_vs_raw;
            r1_cx     <= CX_W'(w_h_cnt % 10'(H_SQUARE));
            r1_cy     <= CY_W'(w_v_cnt % 10'(V_SQUARE));
        end
    end

    // Game-over flash counter: counts frames while game_over, cleared otherwise
    always_ff @(posedge vga_clk or posedge reset_p) begin
        if (reset_p) begin
            r_flash_cnt <= 5'd0;
        end else if (frame_tick) begin
            r_flash_cnt <= game_over ? r_flash_cnt + 5'd1 : 5'd0;
        end
    end

    assign w_flash_on = game_over && r_flash_cnt[FLASH_BIT];

    // Colour map for the pixel currently in stage 1
    always_comb begin
        w_rgb = COL_BLACK;
        if (r1_active) begin
            if (game_state == STATE_INGAME) begin
                case (entity)
                    ENT_W'(ENT_NOTHING):    w_rgb = w_flash_on ? COL_FLASH : COL_BLACK;
                    ENT_W'(ENT_WALL):       w_rgb = COL_WALL;
                    ENT_W'(ENT_APPLE):      w_rgb = COL_APPLE;
                    ENT_W'(ENT_SNAKE_HEAD): w_rgb = COL_HEAD;
                    ENT_W'(ENT_SNAKE_TAIL): w_rgb = ((r1_cx == '0) || (r1_cy == '0))
                                                    ? COL_TAIL_EDGE : COL_TAIL;
                    default:                w_rgb = COL_ERROR;
                endcase
            end else if (game_state == STATE_TEST) begin
                w_rgb = test_palette(entity[2:0]);
            end
        end
    end

    // Stage 2: colour and syncs registered together so they stay aligned
    always_ff @(posedge vga_clk or posedge reset_p) begin
        if (reset_p) begin
            rgb   <= COL_BLACK;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
        end else begin
            rgb   <= w_rgb;
            hsync <= r1_hs ? SYNC_POL : ~SYNC_POL;
            vsync <= r1_vs ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_entity_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_entity_renderer
// Description : Directed self-checking bench for entity_renderer using a
//               reduced raster (80x30 total, 64x24 visible) and a small
//               game-logic model that returns entity codes one cycle late.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_entity_renderer;

    logic        clk = 1'b0;
    logic        reset_p;
    logic [3:0]  entity;
    logic [2:0]  game_state;
    logic        game_over;
    logic [9:0]  x_out;
    logic [9:0]  y_out;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    // Game-logic model controls
    int         mode      = 0;
    logic [3:0] const_ent = 4'd0;
    logic [9:0] px = 10'd0;
    logic [9:0] py = 10'd0;

    always #5 clk = ~clk;

    entity_renderer #(
        .H_VISIBLE (64),
        .H_FP      (4),
        .H_SYNC    (8),
        .H_BP      (4),
        .V_VISIBLE (24),
        .V_FP      (2),
        .V_SYNC    (2),
        .V_BP      (2),
        .SYNC_POL  (1'b0),
        .ENT_W     (4),
        .FLASH_BIT (1)
    ) dut (
        .vga_clk    (clk),
        .reset_p    (reset_p),
        .entity     (entity),
        .game_state (game_state),
        .game_over  (game_over),
        .x_out      (x_out),
        .y_out      (y_out),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .frame_tick (frame_tick)
    );

    function automatic logic [3:0] ent_model(input logic [9:0] x, input logic [9:0] y);
        case (mode)
            0:       return const_ent;
            1:       return (x == 10'd40 && y == 10'd10) ? 4'd3 : 4'd0;
            2:       return (x >= 10'd32 && x < 10'd48 && y >= 10'd16 && y < 10'd32) ? 4'd2 : 4'd0;
            default: return {1'b1, x[5:3]};
        endcase
    endfunction

    // Game logic: entity for the coordinate seen on the previous cycle
    always @(negedge clk) begin
        entity = ent_model(px, py);
        px = x_out;
        py = y_out;
    end

    task automatic wait_xy(input int x, input int y);
        int n;
        n = 0;
        @(negedge clk);
        while (!(x_out == 10'(x) && y_out == 10'(y))) begin
            n++;
            if (n > 3000) begin
                total++; bad++;
                $display("FAIL wait_xy(%0d,%0d) timeout: at (%0d,%0d)", x, y, x_out, y_out);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_tick;
        int n;
        n = 0;
        @(negedge clk);
        while (frame_tick !== 1'b1) begin
            n++;
            if (n > 3000) begin
                total++; bad++;
                $display("FAIL wait_tick timeout");
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_p = 1'b1; game_state = 3'd0; game_over = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (x_out !== 10'd0)    begin bad++; $display("FAIL rst_x got=%0d exp=0", x_out); end
        total++; if (y_out !== 10'd0)    begin bad++; $display("FAIL rst_y got=%0d exp=0", y_out); end
        total++; if (rgb !== 12'h000)    begin bad++; $display("FAIL rst_rgb got=%h exp=000", rgb); end
        total++; if (hsync !== 1'b1)     begin bad++; $display("FAIL rst_hsync got=%b exp=1", hsync); end
        total++; if (vsync !== 1'b1)     begin bad++; $display("FAIL rst_vsync got=%b exp=1", vsync); end
        total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL rst_tick got=%b exp=0", frame_tick); end
    endtask

    task automatic test_sync_timing;
        int hs_low, vs_low, ticks, first_tick, last_tick, period_err, align_err;
        int p, x2, y2;
        logic hs_exp, vs_exp;
        hs_low = 0; vs_low = 0; ticks = 0; first_tick = -1; last_tick = -1;
        period_err = 0; align_err = 0;
        reset_p = 1'b0;
        for (int i = 0; i < 4800; i++) begin
            if (i > 0) @(negedge clk);
            if (hsync === 1'b0) hs_low++;
            if (vsync === 1'b0) vs_low++;
            if (i < 2) begin
                hs_exp = 1'b1; vs_exp = 1'b1;
            end else begin
                p  = i - 2;
                x2 = p % 80;
                y2 = (p / 80) % 30;
                hs_exp = !(x2 >= 68 && x2 < 76);
                vs_exp = !(y2 >= 26 && y2 < 28);
            end
            if (hsync !== hs_exp || vsync !== vs_exp) align_err++;
            if (frame_tick === 1'b1) begin
                ticks++;
                if (first_tick < 0) first_tick = i;
                if (last_tick >= 0 && (i - last_tick) != 2400) period_err++;
                last_tick = i;
            end
        end
        total++; if (hs_low != 480)    begin bad++; $display("FAIL hs_low_cycles got=%0d exp=480", hs_low); end
        total++; if (vs_low != 320)    begin bad++; $display("FAIL vs_low_cycles got=%0d exp=320", vs_low); end
        total++; if (ticks != 2)       begin bad++; $display("FAIL tick_count got=%0d exp=2", ticks); end
        total++; if (first_tick != 1920) begin bad++; $display("FAIL first_tick got=%0d exp=1920", first_tick); end
        total++; if (period_err != 0)  begin bad++; $display("FAIL tick_period errs=%0d exp=0", period_err); end
        total++; if (align_err != 0)   begin bad++; $display("FAIL sync_align errs=%0d exp=0", align_err); end
    endtask

    task automatic test_latency;
        game_state = 3'd1; mode = 1;
        wait_xy(41, 10);
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL lat_pix39 got=%h exp=000", rgb); end
        @(negedge clk);
        total++; if (rgb !== 12'hF00) begin bad++; $display("FAIL lat_apple got=%h exp=F00", rgb); end
        @(negedge clk);
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL lat_pix41 got=%h exp=000", rgb); end
    endtask

    task automatic test_blanking;
        int errs;
        logic [11:0] exp;
        mode = 0; const_ent = 4'd4;
        wait_xy(65, 5);
        total++; if (rgb !== 12'h888) begin bad++; $display("FAIL blank_pix63 got=%h exp=888", rgb); end
        @(negedge clk);
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL blank_pix64 got=%h exp=000", rgb); end
        wait_xy(2, 6);
        total++; if (rgb !== 12'h888) begin bad++; $display("FAIL blank_pix0 got=%h exp=888", rgb); end
        errs = 0;
        wait_xy(2, 7);
        for (int x = 2; x < 80; x++) begin
            if (x > 2) @(negedge clk);
            exp = (x - 2 < 64) ? 12'h888 : 12'h000;
            if (rgb !== exp) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL blank_line7 errs=%0d exp=0", errs); end
        errs = 0;
        wait_xy(0, 26);
        for (int x = 0; x < 80; x++) begin
            if (x > 0) @(negedge clk);
            if (rgb !== 12'h000) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL blank_vline errs=%0d exp=0", errs); end
    endtask

    task automatic test_tail;
        mode = 2;
        wait_xy(34, 16);
        total++; if (rgb !== 12'h050) begin bad++; $display("FAIL tail_32_16 got=%h exp=050", rgb); end
        @(negedge clk);
        total++; if (rgb !== 12'h050) begin bad++; $display("FAIL tail_33_16 got=%h exp=050", rgb); end
        wait_xy(49, 16);
        total++; if (rgb !== 12'h050) begin bad++; $display("FAIL tail_47_16 got=%h exp=050", rgb); end
        wait_xy(34, 17);
        total++; if (rgb !== 12'h050) begin bad++; $display("FAIL tail_32_17 got=%h exp=050", rgb); end
        @(negedge clk);
        total++; if (rgb !== 12'h0A0) begin bad++; $display("FAIL tail_33_17 got=%h exp=0A0", rgb); end
        wait_xy(49, 17);
        total++; if (rgb !== 12'h0A0) begin bad++; $display("FAIL tail_47_17 got=%h exp=0A0", rgb); end
        @(negedge clk);
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL tail_48_17 got=%h exp=000", rgb); end
    endtask

    task automatic test_modes;
        logic [11:0] pal [8] = '{12'h000, 12'hF00, 12'h0F0, 12'h00F,
                                 12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF};
        game_state = 3'd4; mode = 3;
        for (int k = 0; k < 8; k++) begin
            wait_xy(8 * k + 3, 3);
            total++;
            if (rgb !== pal[k]) begin
                bad++; $display("FAIL test_bar%0d got=%h exp=%h", k, rgb, pal[k]);
            end
        end
        game_state = 3'd0; mode = 0; const_ent = 4'd4;
        wait_xy(12, 4);
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL other_state got=%h exp=000", rgb); end
        game_state = 3'd1; const_ent = 4'd7;
        wait_xy(12, 5);
        total++; if (rgb !== 12'hF0F) begin bad++; $display("FAIL bad_code got=%h exp=F0F", rgb); end
        const_ent = 4'd1;
        wait_xy(12, 6);
        total++; if (rgb !== 12'h0F0) begin bad++; $display("FAIL head got=%h exp=0F0", rgb); end
        const_ent = 4'd4;
        wait_xy(20, 8);
        total++; if (rgb !== 12'h888) begin bad++; $display("FAIL midline_pre got=%h exp=888", rgb); end
        game_state = 3'd0;
        @(negedge clk);
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL midline_post got=%h exp=000", rgb); end
    endtask

    task automatic test_flash;
        logic [11:0] exp;
        game_state = 3'd1; mode = 0; const_ent = 4'd0; game_over = 1'b0;
        wait_tick();
        @(negedge clk);
        game_over = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_xy(7, 5);
            exp = (((k >> 1) & 1) != 0) ? 12'h800 : 12'h000;
            total++;
            if (rgb !== exp) begin bad++; $display("FAIL flash_frame%0d got=%h exp=%h", k, rgb, exp); end
        end
        game_over = 1'b0;
        @(negedge clk);
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL flash_off_now got=%h exp=000", rgb); end
        wait_tick();
        @(negedge clk);
        game_over = 1'b1;
        wait_xy(7, 5);
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL flash_cleared got=%h exp=000", rgb); end
        game_over = 1'b0;
    endtask

    task automatic test_reset_midframe;
        int n;
        game_state = 3'd1; mode = 0; const_ent = 4'd4;
        wait_xy(72, 26);
        total++; if (hsync !== 1'b0 || vsync !== 1'b0) begin
            bad++; $display("FAIL pre_rst_sync got=%b%b exp=00", hsync, vsync);
        end
        reset_p = 1'b1;
        #1;
        total++; if (hsync !== 1'b1 || vsync !== 1'b1) begin
            bad++; $display("FAIL rst_sync_now got=%b%b exp=11", hsync, vsync);
        end
        @(negedge clk);
        reset_p = 1'b0;
        wait_xy(32, 12);
        total++; if (rgb !== 12'h888) begin bad++; $display("FAIL pre_rst_rgb got=%h exp=888", rgb); end
        reset_p = 1'b1;
        #1;
        total++; if (rgb !== 12'h000) begin bad++; $display("FAIL rst_rgb_now got=%h exp=000", rgb); end
        total++; if (x_out !== 10'd0 || y_out !== 10'd0) begin
            bad++; $display("FAIL rst_xy_now got=(%0d,%0d) exp=(0,0)", x_out, y_out);
        end
        repeat (2) @(negedge clk);
        reset_p = 1'b0;
        n = 0;
        while (frame_tick !== 1'b1 && n <= 3000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                total++;
                if (x_out !== 10'd1) begin bad++; $display("FAIL post_rst_x got=%0d exp=1", x_out); end
            end
        end
        total++; if (n != 1920) begin bad++; $display("FAIL post_rst_tick got=%0d exp=1920", n); end
    endtask

    initial begin
        reset_p = 1'b1; entity = 4'd0; game_state = 3'd0; game_over = 1'b0;
        test_reset();
        test_sync_timing();
        test_latency();
        test_blanking();
        test_tail();
        test_modes();
        test_flash();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
